mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Load/store unit for the pipelined MIPS core. Sits between the MEM stage and the data bus.
//  Decodes lw/lh/lb/lhu/lbu/sw/sh/sb, drives a single-outstanding req/ack bus with byte enables,
//  and extends load data. Supports wait states and a bus timeout. Stalls the pipeline while busy.
// PARAMETERS
//  DATA_W   32  bus/data width in bits; legal values 32 or 64; lanes = DATA_W/8
//  ADDR_W   32  byte-address width
//  TIMEOUT  15  cycles in BUS state without bus_ack before the access aborts (1..255)
// PORTS
//  clk          in   1          single clock; all state on rising edge
//  reset        in   1          synchronous, active-high
//  req_valid    in   1          MEM stage presents an instruction
//  req_ready    out  1          unit can accept; 1 only in IDLE
//  opcode       in   6          MIPS opcode field
//  addr         in   ADDR_W     effective byte address
//  wdata        in   DATA_W     store source (rt); low bits used for sb/sh/sw
//  busy         out  1          pipeline stall; = !req_ready
//  resp_valid   out  1          one-cycle pulse: access finished (data or exception)
//  rdata_out    out  DATA_W     extended load result, valid with resp_valid
//  exc_adel     out  1          misaligned load, with resp_valid (MEM_ALIGN_EXC_EN only)
//  exc_ades     out  1          misaligned store, with resp_valid (MEM_ALIGN_EXC_EN only)
//  exc_timeout  out  1          bus timeout, with resp_valid
//  bus_req      out  1          held high for the whole bus access
//  bus_we       out  1          1 = store
//  bus_addr     out  ADDR_W     lane-aligned address (low log2(lanes) bits zero)
//  bus_be       out  DATA_W/8   byte enables; lane 0 = bits [7:0] (little-endian)
//  bus_wdata    out  DATA_W     store data replicated across lanes
//  bus_ack      in   1          access complete; bus_rdata valid this cycle
//  bus_rdata    in   DATA_W     read data
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=1; busy, resp_valid, bus_req, bus_we, all exc_* = 0;
//    bus_be, bus_addr, bus_wdata, rdata_out = 0. Reset mid-access aborts immediately.
//    bus_req drops on the reset edge, and a late bus_ack is ignored.
//  - FSM IDLE -> BUS -> RESP -> IDLE.
//    IDLE: req_valid with a memory opcode latches op/addr/wdata and goes to BUS.
//    A non-memory opcode is ignored; the unit stays in IDLE with no response.
//  - BUS: bus_req=1. bus_ack latches extended data and moves to RESP.
//    Counter reaching TIMEOUT without ack moves to RESP with exc_timeout=1 and rdata_out=0.
//  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
//  - Latency: accept at N, bus_req at N+1, earliest ack N+1, resp_valid N+2.
//    Each wait state adds one cycle.
//  - Byte enables, from lane offset o = addr[log2(lanes)-1:0]:
//    b -> one lane o; h -> two lanes o,o+1; w -> four lanes o..o+3 (DATA_W=64 uses addr[2]).
//  - Load extraction: select lanes per o; lb/lh sign-extend, lbu/lhu zero-extend, lw to DATA_W.
//    For DATA_W=64, lw sign-extends to 64 bits.
//  - Store data: sb replicates wdata[7:0] on all lanes, sh replicates wdata[15:0],
//    sw replicates wdata[31:0].
//  - bus_ack outside BUS is ignored. req_valid while busy is ignored; the pipeline holds it.
// CONFIGURATION
//  MEM_ALIGN_EXC_EN defined:
//    h-ops with addr[0]=1, or w-ops with addr[1:0]!=0, skip BUS and go IDLE->RESP.
//    They raise exc_adel (loads) or exc_ades (stores); rdata_out=0; no bus_req.
//  Not defined: exc_adel and exc_ades are tied 0.
//    Misaligned low bits are forced to natural alignment, and the access proceeds normally.
// STRUCTURE
//  - mem_pkg: memCode constants (LW=0000, SW=0001, LH=0010, LB=0011, LHU=0100, LBU=0101,
//    SH=0110, SB=0111, NO=1000), opcode-to-memCode function, and FSM state encoding.
//  - One sub-module, mem_lane_align (combinational): memCode + offset + data
//    -> bus_be, replicated store data, extended load data.
// TESTING
//  1. bus_rdata=32'h8081F2F3, ack with 0 waits:
//     lb @..0 -> rdata_out 32'hFFFFFFF3; lbu @..1 -> 32'h000000F2; lh @..2 -> 32'hFFFF8081.
//     resp_valid lands 2 cycles after accept.
//  2. sb @0x1003, wdata=32'h123456AB -> bus_be 4'b1000, bus_wdata 32'hABABABAB,
//     bus_addr 0x1000, bus_we=1.
//  3. lw with ack delayed 5 cycles -> bus_req high 6 cycles, busy=1 throughout,
//     resp_valid at accept+7.
//  4. No ack -> exc_timeout with resp_valid after TIMEOUT=15 BUS cycles, bus_req low after.
//  5. lh @0x2001: with MEM_ALIGN_EXC_EN -> exc_adel at accept+1, no bus_req;
//     without it -> access at 0x2000, bus_be 4'b0011.
//  6. reset asserted during BUS -> next cycle IDLE, bus_req=0;
//     a following bus_ack produces no resp_valid.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : mem_pkg                                              |
// | Description : Shared types for the load/store unit: memory access  |
// |               codes, opcode decode and FSM state encoding.         |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package mem_pkg;

  // Internal access code, decoupled from the raw MIPS opcode field
  typedef enum logic [3:0] {
    MC_LW  = 4'b0000,
    MC_SW  = 4'b0001,
    MC_LH  = 4'b0010,
    MC_LB  = 4'b0011,
    MC_LHU = 4'b0100,
    MC_LBU = 4'b0101,
    MC_SH  = 4'b0110,
    MC_SB  = 4'b0111,
    MC_NO  = 4'b1000
  } mem_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Anything that is not a load/store maps to MC_NO and is ignored by the unit
  function automatic mem_code_e op_to_code(input logic [5:0] op);
    case (op)
      6'h20:   return MC_LB;
      6'h21:   return MC_LH;
      6'h23:   return MC_LW;
      6'h24:   return MC_LBU;
      6'h25:   return MC_LHU;
      6'h28:   return MC_SB;
      6'h29:   return MC_SH;
      6'h2B:   return MC_SW;
      default: return MC_NO;
    endcase
  endfunction

  function automatic logic is_store(input mem_code_e c);
    return (c == MC_SW) || (c == MC_SH) || (c == MC_SB);
  endfunction

  function automatic logic is_half(input mem_code_e c);
    return (c == MC_LH) || (c == MC_LHU) || (c == MC_SH);
  endfunction

  function automatic logic is_word(input mem_code_e c);
    return (c == MC_LW) || (c == MC_SW);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : mem_lane_align                                       |
// | Description : Combinational lane steering: byte enables, store     |
// |               data replication and load data extraction/extension. |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES  = DATA_W / 8,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  mem_code_e         code_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [LANES-1:0]  be_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] w_shift;

  // Bring the addressed lane down to bit 0 before extension
  assign w_shift = rdata_i >> {off_i, 3'b000};

  // Byte-enable mask, store replication and load extension per access code
  always_comb begin
    be_o    = '0;
    wdata_o = '0;
    rdata_o = '0;
    case (code_i)
      MC_LB, MC_LBU, MC_SB: be_o = LANES'(4'b0001) << off_i;
      MC_LH, MC_LHU, MC_SH: be_o = LANES'(4'b0011) << off_i;
      MC_LW, MC_SW:         be_o = LANES'(4'b1111) << off_i;
      default:              be_o = '0;
    endcase
    case (code_i)
      MC_SB:   wdata_o = {LANES{wdata_i[7:0]}};
      MC_SH:   wdata_o = {(LANES / 2){wdata_i[15:0]}};
      MC_SW:   wdata_o = {(LANES / 4){wdata_i[31:0]}};
      default: wdata_o = '0;
    endcase
    case (code_i)
      MC_LB:   rdata_o = DATA_W'($signed(w_shift[7:0]));
      MC_LBU:  rdata_o = DATA_W'(w_shift[7:0]);
      MC_LH:   rdata_o = DATA_W'($signed(w_shift[15:0]));
      MC_LHU:  rdata_o = DATA_W'(w_shift[15:0]);
      MC_LW:   rdata_o = DATA_W'($signed(w_shift[31:0]));
      default: rdata_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : mem_access_unit                                      |
// | Description : MIPS load/store unit. Single-outstanding req/ack bus |
// |               with byte enables, wait states and bus timeout.      |
// |               Optional MEM_ALIGN_EXC_EN: misaligned h/w accesses   |
// |               raise exc_adel/exc_ades instead of being aligned.    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [5:0]          opcode,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                busy,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   rdata_out,
  output logic                exc_adel,
  output logic                exc_ades,
  output logic                exc_timeout,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_ack,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);

  state_e            state_q, state_d;
  mem_code_e         code_q;
  logic [OFF_W-1:0]  off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [7:0]        cnt_q;
  logic              exc_adel_q, exc_ades_q, exc_to_q;

  mem_code_e         w_code;
  logic              w_accept;
  logic              w_misalign;
  logic              w_timeout;
  logic [OFF_W-1:0]  w_off_nat;
  logic [LANES-1:0]  w_be;
  logic [DATA_W-1:0] w_wrep;
  logic [DATA_W-1:0] w_ext;

  assign w_code    = op_to_code(opcode);
  assign w_accept  = (state_q == ST_IDLE) && req_valid && (w_code != MC_NO);
  assign w_timeout = (cnt_q == 8'(TIMEOUT - 1));

`ifdef MEM_ALIGN_EXC_EN
  assign w_misalign = (is_half(w_code) && addr[0]) ||
                      (is_word(w_code) && (addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // Force half/word lane offsets to natural alignment
  always_comb begin
    w_off_nat = addr[OFF_W-1:0];
    if (is_half(w_code)) begin
      w_off_nat[0] = 1'b0;
    end else if (is_word(w_code)) begin
      w_off_nat[1:0] = 2'b00;
    end
  end

  mem_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .code_i  (code_q),
    .off_i   (off_q),
    .wdata_i (wdata_q),
    .rdata_i (bus_rdata),
    .be_o    (w_be),
    .wdata_o (w_wrep),
    .rdata_o (w_ext)
  );

  // Next-state logic: misaligned accesses bypass the bus entirely
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_accept) state_d = w_misalign ? ST_RESP : ST_BUS;
      ST_BUS:  if (bus_ack || w_timeout) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset aborts any access in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request capture, wait counter, load result and exception flags
  always_ff @(posedge clk) begin
    if (reset) begin
      code_q     <= MC_LW;
      off_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      exc_adel_q <= 1'b0;
      exc_ades_q <= 1'b0;
      exc_to_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            code_q     <= w_code;
            off_q      <= w_off_nat;
            addr_q     <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            wdata_q    <= wdata;
            rdata_q    <= '0;
            cnt_q      <= '0;
            exc_adel_q <= w_misalign && !is_store(w_code);
            exc_ades_q <= w_misalign && is_store(w_code);
          end
        end
        ST_BUS: begin
          cnt_q <= cnt_q + 8'd1;
          if (bus_ack) begin
            rdata_q <= w_ext;
          end else if (w_timeout) begin
            exc_to_q <= 1'b1;
          end
        end
        default: begin
          exc_adel_q <= 1'b0;
          exc_ades_q <= 1'b0;
          exc_to_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign busy        = !req_ready;
  assign resp_valid  = (state_q == ST_RESP);
  assign rdata_out   = rdata_q;
  assign exc_adel    = exc_adel_q;
  assign exc_ades    = exc_ades_q;
  assign exc_timeout = exc_to_q;
  assign bus_req     = (state_q == ST_BUS);
  assign bus_we      = bus_req && is_store(code_q);
  assign bus_addr    = addr_q;
  assign bus_be      = bus_req ? w_be : '0;
  assign bus_wdata   = bus_req ? w_wrep : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_mem_access_unit                                   |
// | Description : Directed self-checking bench for mem_access_unit.    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_mem_access_unit;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  opcode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        resp_valid;
  logic [31:0] rdata_out;
  logic        exc_adel;
  logic        exc_ades;
  logic        exc_timeout;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks   = 0;
  int failures = 0;

  // Observations captured by run_access
  int          o_lat;
  int          o_buscyc;
  logic        o_busy_ok;
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic [3:0]  o_be;
  logic        o_we, o_adel, o_ades, o_to, o_post_resp, o_post_req;

  always #5 clk = ~clk;

  mem_access_unit #(
    .DATA_W  (32),
    .ADDR_W  (32),
    .TIMEOUT (15)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .opcode      (opcode),
    .addr        (addr),
    .wdata       (wdata),
    .busy        (busy),
    .resp_valid  (resp_valid),
    .rdata_out   (rdata_out),
    .exc_adel    (exc_adel),
    .exc_ades    (exc_ades),
    .exc_timeout (exc_timeout),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_be      (bus_be),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata)
  );

  // Issue one access; acks after 'waits' wait states (huge waits = never).
  // o_lat counts cycles from accept to resp_valid, -1 if it never came.
  task automatic run_access(input logic [5:0] op, input logic [31:0] a,
                            input logic [31:0] wd, input int waits,
                            input logic [31:0] rd);
    o_lat = -1; o_buscyc = 0; o_busy_ok = 1'b1;
    o_rdata = '0; o_addr = '0; o_wdata = '0; o_be = '0;
    o_we = 1'b0; o_adel = 1'b0; o_ades = 1'b0; o_to = 1'b0;
    req_valid = 1'b1; opcode = op; addr = a; wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; opcode = 6'h00; addr = '0; wdata = '0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (resp_valid) begin
        o_lat = cyc; o_rdata = rdata_out;
        o_adel = exc_adel; o_ades = exc_ades; o_to = exc_timeout;
        break;
      end
      if (!busy) o_busy_ok = 1'b0;
      if (bus_req) begin
        if (o_buscyc == 0) begin
          o_be = bus_be; o_addr = bus_addr; o_wdata = bus_wdata; o_we = bus_we;
        end
        o_buscyc++;
        if (o_buscyc == waits + 1) begin
          bus_ack = 1'b1; bus_rdata = rd;
        end
      end
      @(posedge clk); #1;
      bus_ack = 1'b0;
    end
    @(posedge clk); #1;
    o_post_resp = resp_valid;
    o_post_req  = bus_req;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; opcode = '0; addr = '0; wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    checks++;
    if ({req_ready, busy, resp_valid, bus_req, bus_we} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=10000", {req_ready, busy, resp_valid, bus_req, bus_we});
    end
    checks++;
    if ({exc_adel, exc_ades, exc_timeout} !== 3'b000) begin
      failures++;
      $display("FAIL reset_exc got=%b exp=000", {exc_adel, exc_ades, exc_timeout});
    end
    checks++;
    if ({bus_be, bus_addr, bus_wdata, rdata_out} !== 100'd0) begin
      failures++;
      $display("FAIL reset_data be=%h addr=%h wdata=%h rdata=%h exp=all zero", bus_be, bus_addr, bus_wdata, rdata_out);
    end
  endtask

  task automatic test_loads();
    run_access(OP_LB, 32'h0000_0100, '0, 0, 32'h8081F2F3);
    checks++;
    if (o_rdata !== 32'hFFFFFFF3) begin failures++; $display("FAIL lb_data got=%h exp=FFFFFFF3", o_rdata); end
    checks++;
    if (o_lat !== 2) begin failures++; $display("FAIL lb_latency got=%0d exp=2", o_lat); end
    checks++;
    if ({o_be, o_we} !== 5'b0001_0) begin failures++; $display("FAIL lb_be_we got=%b exp=00010", {o_be, o_we}); end
    run_access(OP_LBU, 32'h0000_0101, '0, 0, 32'h8081F2F3);
    checks++;
    if (o_rdata !== 32'h000000F2) begin failures++; $display("FAIL lbu_data got=%h exp=000000F2", o_rdata); end
    run_access(OP_LH, 32'h0000_0102, '0, 0, 32'h8081F2F3);
    checks++;
    if (o_rdata !== 32'hFFFF8081) begin failures++; $display("FAIL lh_data got=%h exp=FFFF8081", o_rdata); end
    checks++;
    if (o_be !== 4'b1100) begin failures++; $display("FAIL lh_be got=%b exp=1100", o_be); end
    run_access(OP_LHU, 32'h0000_0102, '0, 0, 32'h8081F2F3);
    checks++;
    if (o_rdata !== 32'h00008081) begin failures++; $display("FAIL lhu_data got=%h exp=00008081", o_rdata); end
    run_access(OP_LB, 32'h0000_0103, '0, 0, 32'h8081F2F3);
    checks++;
    if (o_rdata !== 32'hFFFFFF80) begin failures++; $display("FAIL lb3_data got=%h exp=FFFFFF80", o_rdata); end
    run_access(OP_LW, 32'h0000_0104, '0, 0, 32'h8081F2F3);
    checks++;
    if ({o_rdata, o_be, o_addr} !== {32'h8081F2F3, 4'b1111, 32'h0000_0104}) begin
      failures++; $display("FAIL lw_data got=%h be=%b addr=%h exp=8081F2F3 1111 00000104", o_rdata, o_be, o_addr);
    end
    checks++;
    if ({o_post_resp, o_post_req} !== 2'b00) begin failures++; $display("FAIL resp_pulse got=%b exp=00", {o_post_resp, o_post_req}); end
  endtask

  task automatic test_stores();
    run_access(OP_SB, 32'h0000_1003, 32'h123456AB, 0, '0);
    checks++;
    if ({o_be, o_wdata, o_addr, o_we} !== {4'b1000, 32'hABABABAB, 32'h0000_1000, 1'b1}) begin
      failures++; $display("FAIL sb_bus be=%b wdata=%h addr=%h we=%b exp=1000 ABABABAB 00001000 1", o_be, o_wdata, o_addr, o_we);
    end
    run_access(OP_SH, 32'h0000_1002, 32'h0000BEEF, 0, '0);
    checks++;
    if ({o_be, o_wdata} !== {4'b1100, 32'hBEEFBEEF}) begin
      failures++; $display("FAIL sh_bus be=%b wdata=%h exp=1100 BEEFBEEF", o_be, o_wdata);
    end
    run_access(OP_SW, 32'h0000_1004, 32'hDEADBEEF, 0, '0);
    checks++;
    if ({o_be, o_wdata, o_addr, o_we} !== {4'b1111, 32'hDEADBEEF, 32'h0000_1004, 1'b1}) begin
      failures++; $display("FAIL sw_bus be=%b wdata=%h addr=%h we=%b exp=1111 DEADBEEF 00001004 1", o_be, o_wdata, o_addr, o_we);
    end
  endtask

  task automatic test_wait_states();
    run_access(OP_LW, 32'h0000_0200, '0, 5, 32'hCAFEF00D);
    checks++;
    if (o_buscyc !== 6) begin failures++; $display("FAIL wait_bus_cycles got=%0d exp=6", o_buscyc); end
    checks++;
    if (o_lat !== 7) begin failures++; $display("FAIL wait_latency got=%0d exp=7", o_lat); end
    checks++;
    if (o_busy_ok !== 1'b1) begin failures++; $display("FAIL wait_busy got=%b exp=1", o_busy_ok); end
    checks++;
    if (o_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL wait_data got=%h exp=CAFEF00D", o_rdata); end
  endtask

  task automatic test_timeout();
    run_access(OP_LW, 32'h0000_0300, '0, 1000, 32'h11111111);
    checks++;
    if (o_lat !== 16) begin failures++; $display("FAIL to_latency got=%0d exp=16", o_lat); end
    checks++;
    if ({o_to, o_rdata} !== {1'b1, 32'h0}) begin failures++; $display("FAIL to_flag exc=%b rdata=%h exp=1 00000000", o_to, o_rdata); end
    checks++;
    if (o_buscyc !== 15) begin failures++; $display("FAIL to_bus_cycles got=%0d exp=15", o_buscyc); end
    checks++;
    if (o_post_req !== 1'b0) begin failures++; $display("FAIL to_req_drop got=%b exp=0", o_post_req); end
  endtask

  task automatic test_misalign();
    run_access(OP_LH, 32'h0000_2001, '0, 0, 32'h1234C0DE);
`ifdef MEM_ALIGN_EXC_EN
    checks++;
    if ({o_lat, o_buscyc} !== {32'd1, 32'd0}) begin failures++; $display("FAIL adel_timing lat=%0d buscyc=%0d exp=1 0", o_lat, o_buscyc); end
    checks++;
    if ({o_adel, o_ades, o_rdata} !== {2'b10, 32'h0}) begin failures++; $display("FAIL adel_flags got=%b%b rdata=%h exp=10 00000000", o_adel, o_ades, o_rdata); end
    run_access(OP_SW, 32'h0000_2002, 32'h55555555, 0, '0);
    checks++;
    if ({o_adel, o_ades, o_buscyc} !== {2'b01, 32'd0}) begin failures++; $display("FAIL ades_flags got=%b%b buscyc=%0d exp=01 0", o_adel, o_ades, o_buscyc); end
`else
    checks++;
    if ({o_addr, o_be} !== {32'h0000_2000, 4'b0011}) begin failures++; $display("FAIL lh_force_align addr=%h be=%b exp=00002000 0011", o_addr, o_be); end
    checks++;
    if ({o_rdata, o_adel} !== {32'hFFFFC0DE, 1'b0}) begin failures++; $display("FAIL lh_force_data got=%h adel=%b exp=FFFFC0DE 0", o_rdata, o_adel); end
`endif
  endtask

  task automatic test_non_memory();
    logic seen;
    seen = 1'b0;
    req_valid = 1'b1; opcode = 6'h08; addr = 32'h40;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus_req || resp_valid || !req_ready) seen = 1'b1;
    end
    req_valid = 1'b0; opcode = 6'h00;
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL non_mem_ignored got=%b exp=0", seen); end
  endtask

  task automatic test_reset_mid_bus();
    logic seen;
    seen = 1'b0;
    req_valid = 1'b1; opcode = OP_LW; addr = 32'h0000_0400;
    @(posedge clk); #1;
    req_valid = 1'b0; opcode = 6'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus_req !== 1'b1) begin failures++; $display("FAIL rst_pre_bus got=%b exp=1", bus_req); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if ({bus_req, req_ready, busy} !== 3'b010) begin failures++; $display("FAIL rst_abort got=%b exp=010", {bus_req, req_ready, busy}); end
    bus_ack = 1'b1; bus_rdata = 32'h77777777;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid || bus_req) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL late_ack_ignored got=%b exp=0", seen); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_wait_states();
    test_timeout();
    test_misalign();
    test_non_memory();
    test_reset_mid_bus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
